parking_gate_ctrl: RTL

Parametrised parking-lot gate controller; the successor of the fixed 4-space lot FSM.
- Tracks free spaces for a lot of CAPACITY spaces and arbitrates enter/exit requests at a single shared gate.
- Holds the door open for a programmable number of cycles.
- Reports full/empty status and denied entries.
- Sits between the gate sensors/ticket logic and the door actuator and display.

---
 rtl/parking_gate_ctrl_pkg.sv | 13 +
 rtl/parking_gate_ctrl_door_timer.sv | 33 +++
 rtl/parking_gate_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/parking_gate_ctrl_pkg.sv
// Shared types and helpers for the parking gate controller.
package parking_pkg;

    typedef enum logic {IDLE, OPEN} gate_state_t;

    localparam int STAT_W = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/parking_gate_ctrl_door_timer.sv
// Door hold timer: a load pulse starts a DOOR_CYCLES-long busy window;
// done is high during the last cycle of that window.
module door_timer #(
    parameter int DOOR_CYCLES = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic load,
    output logic busy,
    output logic done
);

    localparam int TW = $clog2(DOOR_CYCLES + 1);

    logic [TW-1:0] tmr;

    // Load DOOR_CYCLES-1 and count down to zero; busy covers every count value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tmr  <= '0;
            busy <= 1'b0;
        end else if (load) begin
            tmr  <= TW'(DOOR_CYCLES - 1);
            busy <= 1'b1;
        end else if (busy) begin
            if (tmr == '0) busy <= 1'b0;
            else           tmr  <= tmr - TW'(1);
        end
    end

    assign done = busy && (tmr == '0);

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking-lot gate controller: free-space count, enter/exit arbitration at a
// shared gate, timed door hold. Optional counters enabled by PARKING_STATS_EN.
import parking_pkg::*;

module parking_gate_ctrl #(
    parameter  int CAPACITY    = 4,
    parameter  int DOOR_CYCLES = 8,
    localparam int CW          = $clog2(CAPACITY + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          enter_req,
    input  logic          exit_req,
    output logic [CW-1:0] free_cnt,
    output logic          full,
    output logic          empty,
    output logic          enter_grant,
    output logic          exit_grant,
    output logic          deny,
    output logic          door_open
`ifdef PARKING_STATS_EN
    ,
    output logic [STAT_W-1:0] entries_total,
    output logic [STAT_W-1:0] denies_total
`endif
);

    gate_state_t state;
    logic        idle, eg_d, xg_d, dn_d, load;
    logic        tmr_busy, tmr_done;

    assign full  = (free_cnt == '0);
    assign empty = (free_cnt == CW'(CAPACITY));

    // Decisions only happen in IDLE. Both requests on a full lot swap cars;
    // both on an empty lot admits the entrant and drops the stray exit.
    assign idle = (state == IDLE);
    assign eg_d = idle && enter_req && (!full || exit_req);
    assign xg_d = idle && exit_req && !empty;
    assign dn_d = idle && enter_req && full && !exit_req;
    assign load = eg_d || xg_d;

    door_timer #(.DOOR_CYCLES(DOOR_CYCLES)) u_timer (
        .CLK  (CLK),
        .RST  (RST),
        .load (load),
        .busy (tmr_busy),
        .done (tmr_done)
    );

    // Gate FSM with registered pulses, door drive and free-space count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            free_cnt    <= CW'(CAPACITY);
            enter_grant <= 1'b0;
            exit_grant  <= 1'b0;
            deny        <= 1'b0;
            door_open   <= 1'b0;
        end else begin
            enter_grant <= eg_d;
            exit_grant  <= xg_d;
            deny        <= dn_d;
            if (eg_d && !xg_d)      free_cnt <= free_cnt - CW'(1);
            else if (xg_d && !eg_d) free_cnt <= free_cnt + CW'(1);
            case (state)
                IDLE: if (load) begin
                    state     <= OPEN;
                    door_open <= 1'b1;
                end
                OPEN: if (tmr_done) begin
                    state     <= IDLE;
                    door_open <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PARKING_STATS_EN
    // Lifetime entry/deny counters, saturating.
    always_ff @(posedge CLK) begin
        if (RST) begin
            entries_total <= '0;
            denies_total  <= '0;
        end else begin
            if (eg_d) entries_total <= sat_inc(entries_total);
            if (dn_d) denies_total  <= sat_inc(denies_total);
        end
    end
`endif

    a_cnt_range: assert property (@(posedge CLK) disable iff (RST)
        free_cnt <= CW'(CAPACITY));
    a_timer_sync: assert property (@(posedge CLK) disable iff (RST)
        (state == OPEN) == tmr_busy);

endmodule
